// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data memory between the CPU load/store path
// and one external requester (DMA / debug host), with starvation guard.
module dmem_arbiter #(
  parameter int BITS     = 32,
  parameter int MAX_WAIT = 4,
  parameter int MAX_LOCK = 8
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic            cpu_req,
  input  logic            cpu_rw_,
  input  logic [BITS-1:0] cpu_addr,
  input  logic [BITS-1:0] cpu_wdata,
  input  logic [3:0]      cpu_byte_en,
  input  logic            cpu_lock,
  input  logic            ext_req,
  input  logic            ext_rw_,
  input  logic [BITS-1:0] ext_addr,
  input  logic [BITS-1:0] ext_wdata,
  input  logic [3:0]      ext_byte_en,
  input  logic            ext_lock,
  output logic            cpu_gnt,
  output logic            ext_gnt,
  output logic            cpu_stall,
  output logic [BITS-1:0] cpu_rdata,
  output logic [BITS-1:0] ext_rdata,
  output logic [BITS-1:0] mem_addr,
  output logic [BITS-1:0] mem_wdata,
  output logic            mem_rw_,
  output logic [3:0]      mem_byte_en,
  input  logic [BITS-1:0] mem_rdata,
  output logic            snoop_valid,
  output logic [BITS-1:0] snoop_addr
);

  localparam int LW = $clog2(MAX_LOCK + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [LW-1:0] LOCK_LIM = LW'(MAX_LOCK);
  localparam logic [WW-1:0] WAIT_LIM = WW'(MAX_WAIT);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_EXT
  } owner_t;

  owner_t        lock_owner;
  logic [LW-1:0] lock_cnt;
  logic [WW-1:0] wait_cnt;

  logic lock_ok;
  logic cpu_lk;
  logic ext_lk;
  logic starve;

  assign lock_ok = lock_cnt < LOCK_LIM;
  assign cpu_lk  = (lock_owner == OWN_CPU)
                 & cpu_req & lock_ok;
  assign ext_lk  = (lock_owner == OWN_EXT)
                 & ext_req & lock_ok;
  assign starve  = cpu_req & ext_req
                 & (wait_cnt == WAIT_LIM);

  // Priority arbitration: live lock, starvation, CPU, then external.
  always_comb begin
    cpu_gnt = 1'b0;
    ext_gnt = 1'b0;
    priority case (1'b1)
      cpu_lk:  cpu_gnt = 1'b1;
      ext_lk:  ext_gnt = 1'b1;
      starve:  ext_gnt = 1'b1;
      cpu_req: cpu_gnt = 1'b1;
      ext_req: ext_gnt = 1'b1;
      default: ;
    endcase
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign cpu_rdata = mem_rdata;
  assign ext_rdata = mem_rdata;

  // Memory mux; idle drives a harmless read with no byte lanes.
  always_comb begin
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_rw_     = 1'b1;
    mem_byte_en = 4'h0;
    if (cpu_gnt) begin
      mem_addr    = cpu_addr;
      mem_wdata   = cpu_wdata;
      mem_rw_     = cpu_rw_;
      mem_byte_en = cpu_byte_en;
    end else if (ext_gnt) begin
      mem_addr    = ext_addr;
      mem_wdata   = ext_wdata;
      mem_rw_     = ext_rw_;
      mem_byte_en = ext_byte_en;
    end
  end

  // Burst lock owner and length; forced release at the limit.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      lock_owner <= OWN_NONE;
      lock_cnt   <= '0;
    end else if (cpu_gnt && cpu_lock && lock_ok) begin
      lock_owner <= OWN_CPU;
      lock_cnt   <= (lock_owner == OWN_CPU)
                  ? lock_cnt + LW'(1) : LW'(1);
    end else if (ext_gnt && ext_lock && lock_ok) begin
      lock_owner <= OWN_EXT;
      lock_cnt   <= (lock_owner == OWN_EXT)
                  ? lock_cnt + LW'(1) : LW'(1);
    end else begin
      lock_owner <= OWN_NONE;
      lock_cnt   <= '0;
    end
  end

  // External starvation counter, saturating.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wait_cnt <= '0;
    end else if (ext_req && !ext_gnt) begin
      if (wait_cnt != WAIT_LIM)
        wait_cnt <= wait_cnt + WW'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Snoop pulse for granted external writes.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      snoop_valid <= 1'b0;
      snoop_addr  <= '0;
    end else begin
      snoop_valid <= ext_gnt & ~ext_rw_;
      if (ext_gnt && !ext_rw_)
        snoop_addr <= ext_addr;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of arbitration, locking,
// starvation, snoop and reset behaviour of dmem_arbiter.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_;
  logic        cpu_req, cpu_rw_, cpu_lock;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_byte_en;
  logic        ext_req, ext_rw_, ext_lock;
  logic [31:0] ext_addr, ext_wdata;
  logic [3:0]  ext_byte_en;
  logic        cpu_gnt, ext_gnt, cpu_stall;
  logic [31:0] cpu_rdata, ext_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rw_;
  logic [3:0]  mem_byte_en;
  logic        snoop_valid;
  logic [31:0] snoop_addr;

  int n_chk;
  int n_fail;

  logic [31:0] mem [0:63];

  dmem_arbiter #(
    .BITS(32), .MAX_WAIT(4), .MAX_LOCK(8)
  ) dut (
    .clk(clk), .rst_(rst_),
    .cpu_req(cpu_req), .cpu_rw_(cpu_rw_),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_byte_en(cpu_byte_en), .cpu_lock(cpu_lock),
    .ext_req(ext_req), .ext_rw_(ext_rw_),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_byte_en(ext_byte_en), .ext_lock(ext_lock),
    .cpu_gnt(cpu_gnt), .ext_gnt(ext_gnt),
    .cpu_stall(cpu_stall),
    .cpu_rdata(cpu_rdata), .ext_rdata(ext_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rw_(mem_rw_), .mem_byte_en(mem_byte_en),
    .mem_rdata(mem_rdata),
    .snoop_valid(snoop_valid), .snoop_addr(snoop_addr)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  assign mem_rdata = mem[mem_addr[5:0]];

  always @(posedge clk) begin
    if (!mem_rw_) begin
      for (int b = 0; b < 4; b++)
        if (mem_byte_en[b])
          mem[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic cpu_drv(input logic req, input logic rw,
                         input logic [31:0] a,
                         input logic [31:0] d,
                         input logic [3:0] be,
                         input logic lk);
    cpu_req = req; cpu_rw_ = rw; cpu_addr = a;
    cpu_wdata = d; cpu_byte_en = be; cpu_lock = lk;
  endtask

  task automatic ext_drv(input logic req, input logic rw,
                         input logic [31:0] a,
                         input logic [31:0] d,
                         input logic [3:0] be,
                         input logic lk);
    ext_req = req; ext_rw_ = rw; ext_addr = a;
    ext_wdata = d; ext_byte_en = be; ext_lock = lk;
  endtask

  task automatic idle_inputs();
    cpu_drv(0, 1, 0, 0, 0, 0);
    ext_drv(0, 1, 0, 0, 0, 0);
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_ = 1'b0;
    idle_inputs();
    #5;
    n_chk++;
    if (snoop_valid !== 1'b0 || snoop_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_snoop: got %b/%h want 0/0",
               snoop_valid, snoop_addr);
    end
    n_chk++;
    if (cpu_gnt !== 1'b0 || ext_gnt !== 1'b0 ||
        mem_rw_ !== 1'b1 || mem_byte_en !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_idle: gnt %b%b rw %b be %h want 00 1 0",
               cpu_gnt, ext_gnt, mem_rw_, mem_byte_en);
    end
    cpu_drv(1, 1, 32'h4, 0, 4'hF, 0);
    ext_drv(1, 1, 32'h8, 0, 4'hF, 0);
    #1;
    n_chk++;
    if (cpu_gnt !== 1'b1 || ext_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cpu_prio: gnt %b%b want 10",
               cpu_gnt, ext_gnt);
    end
    next_cycle();
    idle_inputs();
    rst_ = 1'b1;
  endtask

  task automatic test_cpu_alone();
    next_cycle();
    cpu_drv(1, 0, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    #2;
    n_chk++;
    if (cpu_gnt !== 1'b1 || mem_rw_ !== 1'b0 ||
        mem_addr !== 32'h10 || mem_wdata !== 32'hDEADBEEF ||
        cpu_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL cpu_write: gnt %b rw %b a %h d %h st %b",
               cpu_gnt, mem_rw_, mem_addr, mem_wdata, cpu_stall);
    end
    next_cycle();
    cpu_drv(1, 1, 32'h10, 0, 4'hF, 0);
    #2;
    n_chk++;
    if (cpu_gnt !== 1'b1 || cpu_rdata !== 32'hDEADBEEF ||
        cpu_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL cpu_read: gnt %b rd %h st %b want 1 deadbeef 0",
               cpu_gnt, cpu_rdata, cpu_stall);
    end
    next_cycle();
    cpu_drv(1, 0, 32'h10, 32'h11223344, 4'h1, 0);
    #2;
    n_chk++;
    if (mem_byte_en !== 4'h1 || snoop_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL cpu_byte_wr: be %h snoop %b want 1 0",
               mem_byte_en, snoop_valid);
    end
    next_cycle();
    cpu_drv(1, 1, 32'h10, 0, 4'hF, 0);
    #2;
    n_chk++;
    if (cpu_rdata !== 32'hDEADBE44 || snoop_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL cpu_byte_rd: rd %h snoop %b want deadbe44 0",
               cpu_rdata, snoop_valid);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_ext_alone();
    next_cycle();
    ext_drv(1, 1, 32'h10, 0, 4'hF, 0);
    #2;
    n_chk++;
    if (ext_gnt !== 1'b1 || cpu_gnt !== 1'b0 ||
        ext_rdata !== 32'hDEADBE44 || mem_addr !== 32'h10) begin
      n_fail++;
      $display("FAIL ext_read: gnt %b%b rd %h a %h",
               cpu_gnt, ext_gnt, ext_rdata, mem_addr);
    end
    next_cycle();
    idle_inputs();
    #2;
    n_chk++;
    if (snoop_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ext_read_snoop: got %b want 0", snoop_valid);
    end
  endtask

  task automatic test_starvation();
    logic ec;
    next_cycle();
    for (int i = 0; i < 6; i++) begin
      cpu_drv(1, 1, 32'h4, 0, 4'hF, 0);
      ext_drv(1, 1, 32'h8, 0, 4'hF, 0);
      #2;
      ec = (i == 4);
      n_chk++;
      if (ext_gnt !== ec || cpu_gnt !== ~ec ||
          cpu_stall !== ec) begin
        n_fail++;
        $display("FAIL starve_c%0d: gnt %b%b st %b want %b%b %b",
                 i, cpu_gnt, ext_gnt, cpu_stall, ~ec, ec, ec);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_lock_limit();
    logic cg, eg;
    next_cycle();
    for (int i = 0; i < 10; i++) begin
      cpu_drv((i >= 1 && i <= 8), 1, 32'h4, 0, 4'hF, 0);
      ext_drv(1, 1, 32'h8, 0, 4'hF, 1);
      #2;
      cg = (i == 8);
      eg = (i != 8);
      n_chk++;
      if (cpu_gnt !== cg || ext_gnt !== eg) begin
        n_fail++;
        $display("FAIL lock_c%0d: gnt %b%b want %b%b",
                 i, cpu_gnt, ext_gnt, cg, eg);
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_snoop();
    next_cycle();
    ext_drv(1, 0, 32'h24, 32'hCAFEF00D, 4'hF, 0);
    #2;
    n_chk++;
    if (ext_gnt !== 1'b1 || snoop_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL snoop_wr: gnt %b snoop %b want 1 0",
               ext_gnt, snoop_valid);
    end
    next_cycle();
    ext_drv(0, 1, 0, 0, 0, 0);
    #2;
    n_chk++;
    if (snoop_valid !== 1'b1 || snoop_addr !== 32'h24) begin
      n_fail++;
      $display("FAIL snoop_pulse: got %b/%h want 1/24",
               snoop_valid, snoop_addr);
    end
    next_cycle();
    ext_drv(1, 1, 32'h24, 0, 4'hF, 0);
    #2;
    n_chk++;
    if (snoop_valid !== 1'b0 || snoop_addr !== 32'h24 ||
        ext_rdata !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL snoop_end: got %b/%h rd %h want 0/24 cafef00d",
               snoop_valid, snoop_addr, ext_rdata);
    end
    next_cycle();
    ext_drv(1, 0, 32'h30, 32'h1, 4'hF, 0);
    #2;
    n_chk++;
    if (snoop_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL snoop_rd: got %b want 0", snoop_valid);
    end
    next_cycle();
    ext_drv(1, 0, 32'h31, 32'h2, 4'hF, 0);
    #2;
    n_chk++;
    if (snoop_valid !== 1'b1 || snoop_addr !== 32'h30) begin
      n_fail++;
      $display("FAIL snoop_b2b0: got %b/%h want 1/30",
               snoop_valid, snoop_addr);
    end
    next_cycle();
    idle_inputs();
    cpu_drv(1, 0, 32'h32, 32'h3, 4'hF, 0);
    #2;
    n_chk++;
    if (snoop_valid !== 1'b1 || snoop_addr !== 32'h31) begin
      n_fail++;
      $display("FAIL snoop_b2b1: got %b/%h want 1/31",
               snoop_valid, snoop_addr);
    end
    next_cycle();
    idle_inputs();
    #2;
    n_chk++;
    if (snoop_valid !== 1'b0 || snoop_addr !== 32'h31) begin
      n_fail++;
      $display("FAIL snoop_cpu_wr: got %b/%h want 0/31",
               snoop_valid, snoop_addr);
    end
  endtask

  task automatic test_reset_mid_lock();
    logic cg, eg;
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      cpu_drv(1, 1, 32'h4, 0, 4'hF, 1);
      ext_drv(1, 1, 32'h8, 0, 4'hF, 0);
      next_cycle();
    end
    #2;
    n_chk++;
    if (dut.lock_cnt !== 4'd3 || dut.wait_cnt !== 3'd3) begin
      n_fail++;
      $display("FAIL pre_rst: lock_cnt %0d wait_cnt %0d want 3 3",
               dut.lock_cnt, dut.wait_cnt);
    end
    #1 rst_ = 1'b0;
    #1;
    n_chk++;
    if (dut.lock_cnt !== 4'd0 || dut.wait_cnt !== 3'd0 ||
        snoop_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst: lock %0d wait %0d snoop %b want 0 0 0",
               dut.lock_cnt, dut.wait_cnt, snoop_valid);
    end
    rst_ = 1'b1;
    #1;
    for (int i = 0; i < 9; i++) begin
      cg = (i < 8);
      eg = (i == 8);
      n_chk++;
      if (cpu_gnt !== cg || ext_gnt !== eg) begin
        n_fail++;
        $display("FAIL post_rst_c%0d: gnt %b%b want %b%b",
                 i, cpu_gnt, ext_gnt, cg, eg);
      end
      next_cycle();
      #2;
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_idle();
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      idle_inputs();
      #2;
      n_chk++;
      if (mem_rw_ !== 1'b1 || mem_byte_en !== 4'h0 ||
          mem_addr !== 32'h0 || cpu_gnt !== 1'b0 ||
          ext_gnt !== 1'b0 || cpu_stall !== 1'b0 ||
          dut.wait_cnt !== 3'd0) begin
        n_fail++;
        $display("FAIL idle_c%0d: rw %b be %h a %h gnt %b%b wait %0d",
                 i, mem_rw_, mem_byte_en, mem_addr,
                 cpu_gnt, ext_gnt, dut.wait_cnt);
      end
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    test_reset();
    test_cpu_alone();
    test_ext_alone();
    test_starvation();
    test_lock_limit();
    test_snoop();
    test_reset_mid_lock();
    test_idle();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

endmodule
